// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES key schedule (128/192/256).
// Produces one 32-bit schedule word per clock and streams the Nr+1 128-bit
// round keys over a valid/ready interface in ascending round order.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, mode, key  expansion request (mode 0/1/2 = AES-128/192/256), key MSB-aligned
//   busy, err, done   status: expansion running, illegal-request pulse, completion pulse
//   rk_valid/rk_ready round-key handshake; rk_data, rk_idx, rk_last payload
//   rd_idx, rd_key    round-key readback (only with KEYEXP_STORE_EN)
//
// Optional feature macro: KEYEXP_STORE_EN adds a 15-entry round-key store
// written on every handshake and read through rd_idx/rd_key (1-cycle latency).
module aes_key_expander #(
    parameter int unsigned KEY_W = 256,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [KEY_W-1:0] key,
`ifdef KEYEXP_STORE_EN
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key,
`endif
    output logic             busy,
    output logic             err,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_last,
    output logic             done
);

    localparam int unsigned WIDX_W = 6;
    localparam int unsigned J_W    = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_DRAIN
    } state_t;

    // GF(2^8) doubling modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] inv;
        s   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s   = gmul(s, s);
            inv = gmul(inv, s);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic int unsigned key_bits(input logic [1:0] m);
        case (m)
            2'd0:    return 128;
            2'd1:    return 192;
            default: return 256;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_q;
    logic [255:0]        key_q;
    logic [WIDX_W-1:0]   widx_q;
    logic [J_W-1:0]      j_q;
    logic [7:0]          rcon_q;
    logic [IDX_W-1:0]    rnd_q;
    logic [7:0][31:0]    hist_q;     // hist_q[n] = w[i-1-n]
    logic [95:0]         col_q;      // up to three collected words, oldest in MSBs
    logic [1:0]          col_cnt_q;
    logic                err_pend_q;

    logic [3:0]          nk_c;
    logic [IDX_W-1:0]    nr_c;
    logic [WIDX_W-1:0]   last_word_c;
    logic                mode_ok_c;
    logic                hs_c;
    logic                out_free_c;
    logic                accept_c;
    logic                gen_en_c;
    logic                load_out_c;
    logic                done_d;
    logic [7:0][31:0]    key_w_c;
    logic [31:0]         w_prev_c;
    logic [31:0]         w_back_c;
    logic [31:0]         sub_in_c;
    logic [31:0]         sub_out_c;
    logic [31:0]         f_c;
    logic [31:0]         w_new_c;

    // Per-mode schedule geometry
    always_comb begin
        nk_c        = 4'd8;
        nr_c        = IDX_W'(14);
        last_word_c = WIDX_W'(59);
        case (mode_q)
            2'd0: begin
                nk_c        = 4'd4;
                nr_c        = IDX_W'(10);
                last_word_c = WIDX_W'(43);
            end
            2'd1: begin
                nk_c        = 4'd6;
                nr_c        = IDX_W'(12);
                last_word_c = WIDX_W'(51);
            end
            default: ;
        endcase
    end

    assign mode_ok_c  = (mode != 2'd3) && (key_bits(mode) <= KEY_W);
    assign hs_c       = rk_valid && rk_ready;
    assign out_free_c = !rk_valid || rk_ready;

    for (genvar n = 0; n < 8; n++) begin : g_key_word
        assign key_w_c[n] = key_q[255 - 32*n -: 32];
    end

    // Schedule word datapath
    assign w_prev_c = hist_q[0];
    assign w_back_c = hist_q[3'(nk_c - 4'd1)];
    assign sub_in_c = (j_q == '0) ? {w_prev_c[23:0], w_prev_c[31:24]} : w_prev_c;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub_out_c[8*b +: 8] = sbox(sub_in_c[8*b +: 8]);
    end

    always_comb begin
        f_c = w_prev_c;
        if (j_q == '0)
            f_c = sub_out_c ^ {rcon_q, 24'h0};
        else if (j_q == 3'd4 && nk_c == 4'd8)
            f_c = sub_out_c;
    end

    assign w_new_c = (widx_q < WIDX_W'(nk_c)) ? key_w_c[widx_q[2:0]] : (w_back_c ^ f_c);

    // Next-state and control
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        gen_en_c   = 1'b0;
        load_out_c = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (mode_ok_c) state_d = S_GEN;
                end
            end
            S_GEN: begin
                // The fourth word goes straight to the output register, so a
                // full collector can only advance when the output can take it.
                gen_en_c   = (col_cnt_q != 2'd3) || out_free_c;
                load_out_c = gen_en_c && (col_cnt_q == 2'd3);
                if (gen_en_c && widx_q == last_word_c) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (hs_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            key_q      <= '0;
            widx_q     <= '0;
            j_q        <= '0;
            rcon_q     <= 8'h01;
            rnd_q      <= '0;
            hist_q     <= '0;
            col_q      <= '0;
            col_cnt_q  <= '0;
            err_pend_q <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            rk_valid   <= 1'b0;
            rk_data    <= '0;
            rk_idx     <= '0;
            rk_last    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != S_IDLE);
            err_pend_q <= accept_c && !mode_ok_c;
            err        <= err_pend_q;
            done       <= done_d;

            if (accept_c) begin
                mode_q    <= mode;
                key_q     <= 256'(key) << (256 - KEY_W);
                widx_q    <= '0;
                j_q       <= '0;
                rcon_q    <= 8'h01;
                rnd_q     <= '0;
                col_cnt_q <= '0;
            end

            if (gen_en_c) begin
                hist_q <= {hist_q[6:0], w_new_c};
                widx_q <= widx_q + WIDX_W'(1);
                j_q    <= (j_q == J_W'(nk_c - 4'd1)) ? '0 : j_q + J_W'(1);
                if (widx_q >= WIDX_W'(nk_c) && j_q == '0) rcon_q <= xtime(rcon_q);
                if (load_out_c) begin
                    col_cnt_q <= '0;
                end else begin
                    col_q     <= {col_q[63:0], w_new_c};
                    col_cnt_q <= col_cnt_q + 2'd1;
                end
            end

            if (load_out_c) begin
                rk_valid <= 1'b1;
                rk_data  <= {col_q, w_new_c};
                rk_idx   <= rnd_q;
                rk_last  <= (rnd_q == nr_c);
                rnd_q    <= rnd_q + IDX_W'(1);
            end else if (hs_c) begin
                rk_valid <= 1'b0;
            end
        end
    end

`ifdef KEYEXP_STORE_EN
    logic [127:0] store_q [15];

    // Round-key store: written on handshake, survives completion, cleared by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < 15; e++) store_q[e] <= '0;
            rd_key <= '0;
        end else begin
            if (hs_c && rk_idx < IDX_W'(15)) store_q[4'(rk_idx)] <= rk_data;
            rd_key <= (rd_idx < IDX_W'(15)) ? store_q[4'(rd_idx)] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key;
    logic         busy;
    logic         err;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         done;
`ifdef KEYEXP_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    aes_key_expander dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .key      (key),
`ifdef KEYEXP_STORE_EN
        .rd_idx   (rd_idx),
        .rd_key   (rd_key),
`endif
        .busy     (busy),
        .err      (err),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [0:255];
    logic [7:0]   rcon_tab [0:10];
    logic [31:0]  mw [0:59];
    logic [127:0] exp_rk [0:14];
    int           exp_nr;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int bi = 0; bi < 8; bi++)
                r[bi] = inv[bi] ^ inv[(bi+4)%8] ^ inv[(bi+5)%8] ^ inv[(bi+6)%8] ^ inv[(bi+7)%8] ^ c[bi];
            sb[x] = r;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic expand(input int m, input logic [255:0] k);
        int nk;
        logic [31:0] t;
        nk     = 4 + 2*m;
        exp_nr = nk + 6;
        for (int i = 0; i < 4*(exp_nr+1); i++) begin
            if (i < nk) begin
                mw[i] = k[255-32*i -: 32];
            end else begin
                t = mw[i-1];
                if (i % nk == 0)
                    t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
                else if (nk == 8 && i % nk == 4)
                    t = subw(t);
                mw[i] = mw[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= exp_nr; r++)
            exp_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- scoreboard / compare ----------------
    logic [127:0] q_data [$];
    int           q_idx  [$];
    bit           q_last [$];
    logic [127:0] dut_rk [0:14];
    bit           last_hs = 1'b0;
    bit           ready_rand = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            last_hs = 1'b0;
        end else begin
            chk("done_pulse", done, last_hs);
            if (last_hs) chk("busy_after_last", busy, 1'b0);
            last_hs = 1'b0;
            if (rk_valid) begin
                if (q_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rk got idx=%0d want no rk_valid", rk_idx);
                end else begin
                    chk("rk_data", rk_data, q_data[0]);
                    chk("rk_idx", rk_idx, q_idx[0]);
                    chk("rk_last", rk_last, q_last[0]);
                    if (rk_ready) begin
                        if (rk_idx < 15) dut_rk[rk_idx] = rk_data;
                        last_hs = q_last[0];
                        void'(q_data.pop_front());
                        void'(q_idx.pop_front());
                        void'(q_last.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic push_expected(input int m, input logic [255:0] k);
        expand(m, k);
        for (int r = 0; r <= exp_nr; r++) begin
            q_data.push_back(exp_rk[r]);
            q_idx.push_back(r);
            q_last.push_back(r == exp_nr);
        end
    endtask

    // Caller sits at posedge+1 with busy low; returns at posedge+1 of the done cycle.
    task automatic do_run(input int m, input logic [255:0] k, input bit inject);
        int n;
        push_expected(m, k);
        start = 1'b1;
        mode  = 2'(m);
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = rnd256();
        chk("busy_on_accept", busy, 1'b1);
        n = 0;
        while (!rk_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_rk_latency", 128'(n), 128'(4));
        if (inject) begin
            start = 1'b1;
            mode  = 2'd2;
            key   = rnd256();
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("busy_after_ignored_start", busy, 1'b1);
        end
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=no done want=done within 3000 cycles");
        end
        chk("queue_drained", 128'(q_data.size()), 128'(0));
        chk("busy_at_done", busy, 1'b0);
    endtask

    logic [255:0] k128;
    int           n;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        key   = '0;
`ifdef KEYEXP_STORE_EN
        rd_idx = '0;
`endif
        rcon_tab = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        build_sbox();
        chk("model_sbox_00", sb[8'h00], 8'h63);
        chk("model_sbox_53", sb[8'h53], 8'hed);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_data", rk_data, 128'h0);
        chk("rst_rk_idx", rk_idx, 4'h0);
        chk("rst_rk_last", rk_last, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known-answer runs, back to back (each new start lands in the done cycle)
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        do_run(0, k128, 1'b0);
        chk("model_128_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_128_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("dut_128_rk1", dut_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("dut_128_rk10", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        do_run(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeef0badf00d}, 1'b0);
        chk("model_192_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        chk("dut_192_rk12", dut_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        do_run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0);
        chk("model_256_rk14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("dut_256_rk14", dut_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

`ifdef KEYEXP_STORE_EN
        rd_idx = 4'd14;
        @(posedge clk);
        #1;
        chk("store_rd14", rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
        rd_idx = 4'd15;
        @(posedge clk);
        #1;
        chk("store_rd15", rd_key, 128'h0);
`endif

        // Backpressure: rk_ready high about 30% of cycles
        ready_rand = 1'b1;
        do_run(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'(rnd256())}, 1'b0);
        for (int t = 0; t < 4; t++)
            do_run(int'($urandom_range(0, 2)), rnd256(), 1'b0);
        ready_rand = 1'b0;
        @(posedge clk);
        #1;

        // Start while busy must not disturb the running expansion
        do_run(0, rnd256(), 1'b1);

        // Illegal mode
        start = 1'b1;
        mode  = 2'd3;
        key   = rnd256();
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("illegal_busy_t0", busy, 1'b0);
        chk("illegal_err_t0", err, 1'b0);
        @(posedge clk);
        #1;
        chk("illegal_err_pulse", err, 1'b1);
        chk("illegal_busy_t1", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("illegal_err_clear", err, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("illegal_no_rk", rk_valid, 1'b0);

        // Reset in the middle of an expansion, then restart
        k128 = rnd256();
        push_expected(0, k128);
        start = 1'b1;
        mode  = 2'd0;
        key   = k128;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(rk_valid && rk_idx == 4'd5) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_rk5", rk_idx, 4'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rk_valid", rk_valid, 1'b0);
        chk("abort_rk_data", rk_data, 128'h0);
        chk("abort_rk_idx", rk_idx, 4'h0);
        chk("abort_rk_last", rk_last, 1'b0);
        chk("abort_done", done, 1'b0);
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_rk_after_abort", rk_valid, 1'b0);
        end
        do_run(0, k128, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout got=still running want=finished");
        $fatal(1, "timeout");
    end

endmodule
